// File: rtl/calc_seq_ctrl.sv
// Calculator sequencing controller: debounced buttons -> add/mul/sub requests,
// shift-add multiply, double-dabble BCD conversion, registered display word.
module calc_seq_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [25:0] IDLE_VALUE      = 26'd2076021
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  input  logic        up,
  input  logic        mid,
  input  logic        down,
  output logic [25:0] result_bin,
  output logic [31:0] bcd,
  output logic [1:0]  op_code,
  output logic        busy,
  output logic        done,
  output logic [2:0]  fsm_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_CONV, S_DONE} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_MUL, OP_SUB} op_t;

  state_t          state, state_next;
  logic [2:0]      sync1, sync2, deb, deb_prev;
  logic [CW-1:0]   cnt [3];
  logic            req_valid;
  op_t             req_op;
  logic            pend_valid;
  op_t             pend_op;
  op_t             cap_op;
  logic [7:0]      cap_a, cap_b, mplier;
  logic [15:0]     mcand;
  logic [25:0]     acc;
  logic [31:0]     shadow, shadow_adj;
  logic [4:0]      step;

  function automatic logic [31:0] dabble(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 8; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  assign fsm_state  = state;
  assign shadow_adj = dabble(shadow);

  // Button bit order everywhere: {down, mid, up}.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      deb_prev <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1    <= {down, mid, up};
      sync2    <= sync1;
      deb_prev <= deb;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Any debounced change requests the highest-priority held button, or NONE.
  always_comb begin
    req_valid = (deb != deb_prev);
    req_op    = OP_NONE;
    if (deb[0])      req_op = OP_ADD;
    else if (deb[1]) req_op = OP_MUL;
    else if (deb[2]) req_op = OP_SUB;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (pend_valid) state_next = S_LOAD;
      S_LOAD: state_next = (cap_op == OP_MUL) ? S_MUL : S_CONV;
      S_MUL:  if (step == 5'd7) state_next = S_CONV;
      S_CONV: if (step == 5'd25) state_next = S_DONE;
      S_DONE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= OP_NONE;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      shadow     <= '0;
      step       <= '0;
      pend_valid <= 1'b0;
      pend_op    <= OP_NONE;
      result_bin <= '0;
      bcd        <= '0;
      op_code    <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (pend_valid) begin
            cap_a      <= A;
            cap_b      <= B;
            cap_op     <= pend_op;
            pend_valid <= 1'b0;
          end
        end
        S_LOAD: begin
          step   <= '0;
          shadow <= '0;
          case (cap_op)
            OP_ADD:  acc <= {17'd0, {1'b0, cap_a} + {1'b0, cap_b}};
            OP_SUB:  acc <= (cap_a > cap_b) ? {18'd0, cap_a - cap_b} : '0;
            OP_MUL: begin
              acc    <= '0;
              mcand  <= {8'd0, cap_a};
              mplier <= cap_b;
            end
            default: acc <= IDLE_VALUE;
          endcase
        end
        S_MUL: begin
          acc    <= acc + (mplier[0] ? {10'd0, mcand} : 26'd0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          step   <= (step == 5'd7) ? 5'd0 : step + 5'd1;
        end
        S_CONV: begin
          // Rotating acc feeds its MSB each cycle and restores it after 26 steps.
          shadow <= {shadow_adj[30:0], acc[25]};
          acc    <= {acc[24:0], acc[25]};
          step   <= step + 5'd1;
        end
        S_DONE: begin
          bcd        <= shadow;
          result_bin <= acc;
          op_code    <= cap_op;
          done       <= 1'b1;
        end
        default: ;
      endcase
      // A request raised during capture lands after it (last request wins).
      if (req_valid) begin
        pend_valid <= 1'b1;
        pend_op    <= req_op;
      end
    end
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl: vector table plus hand-written sequences
// for glitch rejection, back-to-back requests and mid-operation reset.
module tb_calc_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  A, B;
  logic        up, mid, down;
  logic [25:0] result_bin;
  logic [31:0] bcd;
  logic [1:0]  op_code;
  logic        busy, done;
  logic [2:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] IDLE_BCD = 32'h02076021;
  localparam logic [25:0] IDLE_BIN = 26'd2076021;

  calc_seq_ctrl #(.DEBOUNCE_CYCLES(4), .IDLE_VALUE(26'd2076021)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .up(up), .mid(mid), .down(down),
    .result_bin(result_bin), .bcd(bcd), .op_code(op_code), .busy(busy),
    .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  btn;
    logic [31:0] exp_bcd;
    logic [25:0] exp_bin;
    logic [1:0]  exp_op;
    int          exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic wait_busy(input int budget, output bit seen);
    int n;
    n = 0;
    seen = busy;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = busy;
    end
  endtask

  task automatic wait_done(input int budget, output bit seen, output int cyc);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < budget) begin
      step();
      cyc++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic set_btn(input logic [2:0] b);
    {down, mid, up} = b;
  endtask

  task automatic expect_result(input string name, input logic [31:0] e_bcd,
                               input logic [25:0] e_bin, input logic [1:0] e_op,
                               input int e_lat, input int budget);
    bit seen;
    int cyc;
    wait_done(budget, seen, cyc);
    check({name, "_done_seen"}, 32'(seen), 32'd1);
    check({name, "_latency"}, 32'(cyc), 32'(e_lat));
    check({name, "_bcd"}, bcd, e_bcd);
    check({name, "_bin"}, 32'(result_bin), 32'(e_bin));
    check({name, "_op"}, 32'(op_code), 32'(e_op));
  endtask

  // Release all buttons and expect the resulting NONE request to show IDLE_VALUE.
  task automatic release_and_idle(input string name);
    bit seen;
    set_btn(3'b000);
    wait_busy(40, seen);
    check({name, "_none_busy"}, 32'(seen), 32'd1);
    expect_result({name, "_none"}, IDLE_BCD, IDLE_BIN, 2'd0, 28, 60);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit seen;
    string name;
    name = $sformatf("vec%0d", idx);
    A = v.a;
    B = v.b;
    set_btn(v.btn);
    wait_busy(40, seen);
    check({name, "_busy"}, 32'(seen), 32'd1);
    // Operands must have been latched at capture.
    A = ~v.a;
    B = 8'($urandom_range(0, 255));
    expect_result(name, v.exp_bcd, v.exp_bin, v.exp_op, v.exp_lat, 60);
    check({name, "_state_idle"}, 32'(fsm_state), 32'd0);
    release_and_idle(name);
  endtask

  initial begin
    bit seen;
    int cnt;

    vecs[0] = '{8'd200, 8'd100, 3'b001, 32'h00000300, 26'd300,   2'd1, 28};
    vecs[1] = '{8'd255, 8'd255, 3'b010, 32'h00065025, 26'd65025, 2'd2, 36};
    vecs[2] = '{8'd5,   8'd9,   3'b100, 32'h00000000, 26'd0,     2'd3, 28};
    vecs[3] = '{8'd9,   8'd5,   3'b100, 32'h00000004, 26'd4,     2'd3, 28};
    vecs[4] = '{8'd12,  8'd10,  3'b010, 32'h00000120, 26'd120,   2'd2, 36};
    vecs[5] = '{8'd255, 8'd255, 3'b001, 32'h00000510, 26'd510,   2'd1, 28};
    vecs[6] = '{8'd3,   8'd4,   3'b011, 32'h00000007, 26'd7,     2'd1, 28};

    reset = 1'b1;
    A = '0;
    B = '0;
    set_btn(3'b000);
    repeat (3) step();
    check("rst_bcd", bcd, 32'd0);
    check("rst_bin", 32'(result_bin), 32'd0);
    check("rst_op", 32'(op_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    expect_result("rst_idle", IDLE_BCD, IDLE_BIN, 2'd0, 28, 40);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Short glitch on up must never reach the debounced level.
    set_btn(3'b001);
    step();
    step();
    set_btn(3'b000);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || busy) cnt++;
    end
    check("glitch_no_activity", 32'(cnt), 32'd0);

    // Swap up for mid during the ADD conversion: MUL follows straight after.
    A = 8'd6;
    B = 8'd7;
    set_btn(3'b001);
    wait_busy(40, seen);
    check("b2b_busy", 32'(seen), 32'd1);
    repeat (3) step();
    set_btn(3'b010);
    expect_result("b2b_add", 32'h00000013, 26'd13, 2'd1, 25, 60);
    step();
    check("b2b_mul_immediate", 32'(busy), 32'd1);
    expect_result("b2b_mul", 32'h00000042, 26'd42, 2'd2, 36, 60);
    release_and_idle("b2b");

    // Reset while multiplying aborts and restarts with the NONE sequence.
    A = 8'd255;
    B = 8'd255;
    set_btn(3'b010);
    wait_busy(40, seen);
    check("mrst_busy", 32'(seen), 32'd1);
    repeat (3) step();
    check("mrst_in_mul", 32'(fsm_state), 32'd2);
    reset = 1'b1;
    set_btn(3'b000);
    step();
    check("mrst_busy_low", 32'(busy), 32'd0);
    check("mrst_done_low", 32'(done), 32'd0);
    check("mrst_bcd", bcd, 32'd0);
    check("mrst_op", 32'(op_code), 32'd0);
    reset = 1'b0;
    expect_result("mrst_idle", IDLE_BCD, IDLE_BIN, 2'd0, 28, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
